// File: rtl/sat_pkg.sv
// Shared definitions for the saturating add/sub pipeline: op encodings and the clamp helper.
// Latency: none (package only).
// Backpressure: not applicable.
package sat_pkg;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_ACC_ADD = 2'b10;
  localparam logic [1:0] OP_ACC_SUB = 2'b11;

  // Widest datapath the clamp helper handles; callers pass their own width.
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                 sat;
    logic [SAT_MAX_W-1:0] value;
  } sat_res_t;

  // Clamp a sign-extended (width+1)-bit sum into the signed width-bit range.
  // The low 'width' bits of .value carry the result; .sat flags a clamp.
  function automatic sat_res_t sat_clamp(input logic signed [SAT_MAX_W:0] sum,
                                         input int width);
    logic signed [SAT_MAX_W:0] max_v;
    logic signed [SAT_MAX_W:0] min_v;
    sat_res_t                  r;
    max_v   = ((SAT_MAX_W+1)'(1) << (width - 1)) - (SAT_MAX_W+1)'(1);
    min_v   = -max_v - (SAT_MAX_W+1)'(1);
    r.sat   = 1'b0;
    r.value = sum[SAT_MAX_W-1:0];
    if (sum > max_v) begin
      r.sat   = 1'b1;
      r.value = max_v[SAT_MAX_W-1:0];
    end else if (sum < min_v) begin
      r.sat   = 1'b1;
      r.value = min_v[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_addsub_core.sv
// Combinational saturating add/sub: operand select, shared WIDTH+1 adder, clamp.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module sat_addsub_core #(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] c,
  output logic             sat
);
  import sat_pkg::*;

  logic                   is_acc;
  logic                   sub;
  logic [WIDTH-1:0]       x;
  logic [WIDTH-1:0]       y;
  logic [WIDTH-1:0]       y_inv;
  logic signed [WIDTH:0]  sum;
  sat_res_t               res;

  // Select operands, subtract via invert plus carry-in, then clamp to the signed range.
  always_comb begin
    is_acc = (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
    sub    = op[0];
    x      = is_acc ? acc : a;
    y      = is_acc ? a : b;
    y_inv  = y ^ {WIDTH{sub}};
    sum    = {x[WIDTH-1], x} + {y_inv[WIDTH-1], y_inv} + {{WIDTH{1'b0}}, sub};
    res    = sat_clamp((SAT_MAX_W+1)'(sum), WIDTH);
    c      = WIDTH'(res.value);
    sat    = res.sat;
  end

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage saturating add/sub with accumulator mode; optional status counters under SAT_STATUS_EN.
// Latency: 2 cycles accept-to-valid_out, 1 op/cycle throughput.
// Backpressure: ready_in low freezes both stages; ready_out drops only once stage 1 is also full.
module sat_addsub_pipe #(
  parameter int                      WIDTH    = 16,
  parameter logic signed [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             clr_acc_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] c_out,
  output logic             sat_out
`ifdef SAT_STATUS_EN
  ,
  input  logic             sat_clr_in,
  output logic             sat_sticky_out,
  output logic [15:0]      sat_cnt_out
`endif
);
  import sat_pkg::*;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr;
  } s1_t;

  s1_t              s1_dat;
  logic             s1_vld;
  logic             adv;
  logic             accept;
  logic             s1_is_acc;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] core_c;
  logic             core_sat;

  assign adv       = !valid_out || ready_in;
  assign ready_out = adv || !s1_vld;
  assign accept    = valid_in && ready_out;
  assign s1_is_acc = (s1_dat.op == OP_ACC_ADD) || (s1_dat.op == OP_ACC_SUB);
  // A clear takes effect before the op in the same slot reads the accumulator.
  assign acc_eff   = s1_dat.clr ? ACC_INIT : acc;

  // Stage 1: capture an accepted op; drain when the pipe moves with nothing new.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (accept) begin
      s1_vld <= 1'b1;
      s1_dat <= '{op: op_in, a: a_in, b: b_in, clr: clr_acc_in};
    end else if (adv) begin
      s1_vld <= 1'b0;
    end
  end

  sat_addsub_core #(.WIDTH(WIDTH)) u_core (
    .op  (s1_dat.op),
    .a   (s1_dat.a),
    .b   (s1_dat.b),
    .acc (acc_eff),
    .c   (core_c),
    .sat (core_sat)
  );

  // Stage 2: register the result and retire accumulator updates in op order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out <= 1'b0;
      c_out     <= '0;
      sat_out   <= 1'b0;
      acc       <= ACC_INIT;
    end else if (adv) begin
      valid_out <= s1_vld;
      if (s1_vld) begin
        c_out   <= core_c;
        sat_out <= core_sat;
        if (s1_is_acc) begin
          acc <= core_c;
        end else if (s1_dat.clr) begin
          acc <= ACC_INIT;
        end
      end
    end
  end

`ifdef SAT_STATUS_EN
  logic sat_retire;
  assign sat_retire = adv && s1_vld && core_sat;

  // Sticky flag and saturating count of clamped results; a new clamp beats a clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sat_sticky_out <= 1'b0;
      sat_cnt_out    <= 16'd0;
    end else begin
      if (sat_retire) begin
        sat_sticky_out <= 1'b1;
      end else if (sat_clr_in) begin
        sat_sticky_out <= 1'b0;
      end
      if (sat_clr_in) begin
        sat_cnt_out <= sat_retire ? 16'd1 : 16'd0;
      end else if (sat_retire && (sat_cnt_out != 16'hFFFF)) begin
        sat_cnt_out <= sat_cnt_out + 16'd1;
      end
    end
  end
`else
  // Status counters are not built; the datapath above is unchanged.
`endif

endmodule
